// File: rtl/logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : logic_op_arbiter
// Brief   : Round-robin arbiter sharing one bitwise logic unit among NREQ
//           requesters; a single registered result slot with backpressure.
//           Define LOGIC_ARB_STATS_EN to add the 16-bit grant_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
module logic_op_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [3*NREQ-1:0]      req_op,
    input  logic [WIDTH*NREQ-1:0]  req_a,
    input  logic [WIDTH*NREQ-1:0]  req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic [IDW-1:0]         res_id,
    output logic [2:0]             res_op
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [15:0]            grant_cnt
`endif
);

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;
    logic [2:0]       r_op;

    logic             w_free;
    logic             w_grant_any;
    logic [IDW-1:0]   w_grant_idx;
    logic             w_xfer;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic [IDW-1:0]   w_ptr_next;

    function automatic logic [WIDTH-1:0] logic_unit(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (op)
            3'd0:    logic_unit = a & b;
            3'd1:    logic_unit = a | b;
            3'd2:    logic_unit = ~(a & b);
            3'd3:    logic_unit = ~(a | b);
            3'd4:    logic_unit = a ^ b;
            3'd5:    logic_unit = ~(a ^ b);
            3'd6:    logic_unit = ~a;
            default: logic_unit = ~b;
        endcase
    endfunction

    assign res_valid = (r_state == c_ST_FULL);
    assign w_free    = !res_valid || res_ready;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_grant_any = 1'b1;
                w_grant_idx = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_xfer = w_free && w_grant_any;

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_op       = req_op[3*int'(w_grant_idx) +: 3];
    assign w_a        = req_a[WIDTH*int'(w_grant_idx) +: WIDTH];
    assign w_b        = req_b[WIDTH*int'(w_grant_idx) +: WIDTH];
    assign w_result   = logic_unit(w_op, w_a, w_b);
    assign w_ptr_next = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_EMPTY;
            r_ptr   <= '0;
            r_data  <= '0;
            r_id    <= '0;
            r_op    <= '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_xfer) begin
                        r_state <= c_ST_FULL;
                    end
                end
                default: begin
                    if (res_ready && !w_xfer) begin
                        r_state <= c_ST_EMPTY;
                    end
                end
            endcase
            if (w_xfer) begin
                r_data <= w_result;
                r_id   <= w_grant_idx;
                r_op   <= w_op;
                r_ptr  <= w_ptr_next;
            end
        end
    end

    assign res_data = r_data;
    assign res_id   = r_id;
    assign res_op   = r_op;

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] r_grant_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
        end else if (w_xfer) begin
            r_grant_cnt <= r_grant_cnt + 16'd1;
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_logic_op_arbiter
// Brief   : Self-checking bench for logic_op_arbiter (table vectors plus a
//           result scoreboard). Define LOGIC_ARB_STATS_EN to cover grant_cnt.
// Revision: 1.0 - initial release
// ============================================================================
module tb_logic_op_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic [IDW-1:0]        res_id;
    logic [2:0]            res_op;
`ifdef LOGIC_ARB_STATS_EN
    logic [15:0]           grant_cnt;
`endif

    always #5 clk = ~clk;

    logic_op_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_op    (res_op)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    typedef struct packed {
        logic [1:0] id;
        logic [2:0] op;
        logic [7:0] data;
    } res_t;

    vec_t  tbl [12];
    res_t  exp_q [$];
    int    total = 0;
    int    bad   = 0;
    int    m_ptr = 0;
    int    m_cnt = 0;

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case (op)
                3'd0: r[i] = a[i] && b[i];
                3'd1: r[i] = a[i] || b[i];
                3'd2: r[i] = !(a[i] && b[i]);
                3'd3: r[i] = !(a[i] || b[i]);
                3'd4: r[i] = a[i] != b[i];
                3'd5: r[i] = a[i] == b[i];
                3'd6: r[i] = !a[i];
                default: r[i] = !b[i];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at posedge+1; drives inputs, checks at the negedge, returns at posedge+1.
    task automatic cycle(input logic [3:0] v, input logic [11:0] ops, input logic [31:0] as,
                         input logic [31:0] bs, input logic rdy, input logic use_exp,
                         input logic [7:0] exp_data);
        int         gi;
        logic       fr;
        logic [3:0] er;
        res_t       r;
        req_valid = v;
        req_op    = ops;
        req_a     = as;
        req_b     = bs;
        res_ready = rdy;
        @(negedge clk);
        check("res_valid", res_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("res_data", res_data, exp_q[0].data);
            check("res_id", res_id, exp_q[0].id);
            check("res_op", res_op, exp_q[0].op);
        end
        fr = (exp_q.size() == 0) || rdy;
        gi = -1;
        if (fr) begin
            for (int k = 0; k < NREQ; k++) begin
                if (gi < 0 && v[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
            end
        end
        er = (gi >= 0) ? (4'b0001 << gi) : 4'b0000;
        check("req_ready", req_ready, er);
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (gi >= 0) begin
            r.id   = 2'(gi);
            r.op   = ops[3*gi +: 3];
            r.data = use_exp ? exp_data : ref_op(ops[3*gi +: 3], as[8*gi +: 8], bs[8*gi +: 8]);
            exp_q.push_back(r);
            m_ptr = (gi + 1) % NREQ;
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cycle(input logic [3:0] v, input logic rdy);
        cycle(v, 12'($urandom), $urandom, $urandom, rdy, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        req_valid = '0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_res_data", res_data, 8'h00);
        check("rst_res_id", res_id, 2'd0);
        check("rst_res_op", res_op, 3'd0);
        exp_q.delete();
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{3'd0, 8'hC5, 8'h3A, 8'h00};
        tbl[1]  = '{3'd1, 8'hC5, 8'h3A, 8'hFF};
        tbl[2]  = '{3'd2, 8'hC5, 8'h3A, 8'hFF};
        tbl[3]  = '{3'd3, 8'hC5, 8'h3A, 8'h00};
        tbl[4]  = '{3'd4, 8'hC5, 8'h3A, 8'hFF};
        tbl[5]  = '{3'd5, 8'hC5, 8'h3A, 8'h00};
        tbl[6]  = '{3'd6, 8'hC5, 8'h3A, 8'h3A};
        tbl[7]  = '{3'd7, 8'hC5, 8'h3A, 8'hC5};
        tbl[8]  = '{3'd4, 8'hF0, 8'hCC, 8'h3C};
        tbl[9]  = '{3'd2, 8'hF0, 8'hCC, 8'h3F};
        tbl[10] = '{3'd3, 8'hF0, 8'hCC, 8'h03};
        tbl[11] = '{3'd5, 8'hA5, 8'h5A, 8'h00};

        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        rst_n     = 1'b1;
        #3;
        do_reset();

        // Opcode sweep on requester 0 with table results.
        for (int i = 0; i < 12; i++) begin
            cycle(4'b0001, {9'b0, tbl[i].op}, {24'b0, tbl[i].a}, {24'b0, tbl[i].b},
                  1'b1, 1'b1, tbl[i].exp);
        end
        rnd_cycle(4'b0000, 1'b1);

        // Continuous requests from all four, starting at ptr 0.
        do_reset();
        for (int i = 0; i < 6; i++) rnd_cycle(4'b1111, 1'b1);
        rnd_cycle(4'b0000, 1'b1);

        // Grant 1 leaves ptr at 2; then 3 then 1; ptr back at 2.
        rnd_cycle(4'b0010, 1'b1);
        rnd_cycle(4'b1010, 1'b1);
        rnd_cycle(4'b1010, 1'b1);
        rnd_cycle(4'b1111, 1'b1);
        check("ptr_after_wrap", res_id, 2'd2);
        rnd_cycle(4'b0000, 1'b1);

        // Stall for five cycles, then same-edge consume and transfer.
        rnd_cycle(4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) rnd_cycle(4'b1111, 1'b0);
        rnd_cycle(4'b1111, 1'b1);
        rnd_cycle(4'b0000, 1'b1);
        rnd_cycle(4'b0000, 1'b1);

        // Reset while stalled; first grant afterwards goes to requester 0.
        rnd_cycle(4'b0100, 1'b1);
        rnd_cycle(4'b1111, 1'b0);
        check("stall_valid", res_valid, 1'b1);
        do_reset();
        rnd_cycle(4'b1111, 1'b1);
        check("post_reset_id", res_id, 2'd0);
        rnd_cycle(4'b0000, 1'b1);

`ifdef LOGIC_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 10; i++) rnd_cycle(4'b0001, 1'b1);
        check("grant_cnt_10", grant_cnt, 16'd10);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        repeat (65525) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        check("grant_cnt_max", grant_cnt, 16'hFFFF);
        req_valid = 4'b1111;
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        check("grant_cnt_wrap", grant_cnt, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
